// File: rtl/mem_request_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_request_queue_pkg
// Brief  : Shared types for the parser-to-scheduler request queue.
// Rev    : 1.0  initial release
// ============================================================================
package mem_request_queue_pkg;

    localparam int ADDRESS_WIDTH       = 32;
    localparam int TIMESTAMP_WIDTH     = 32;
    localparam int DEFAULT_QUEUE_DEPTH = 16;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_IFETCH  = 2'd2,
        OP_INVALID = 2'd3
    } parsed_op_t;

    typedef struct packed {
        logic                       op_ready_s;
        parsed_op_t                 opcode;
        logic [ADDRESS_WIDTH-1:0]   address;
        logic [TIMESTAMP_WIDTH-1:0] time_cpu;
    } parser_out_struct_t;

    typedef struct packed {
        parsed_op_t                 opcode;
        logic [ADDRESS_WIDTH-1:0]   address;
        logic [TIMESTAMP_WIDTH-1:0] time_cpu;
        logic [TIMESTAMP_WIDTH-1:0] t_enq;
    } queue_entry_t;

    typedef enum logic [1:0] {
        H_EMPTY = 2'd0,
        H_TIME  = 2'd1,
        H_SPACE = 2'd2
    } hold_state_t;

    function automatic logic is_legal_op(input parsed_op_t op);
        return (op == OP_READ) || (op == OP_WRITE) || (op == OP_IFETCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_request_queue_req_fifo.sv
`default_nettype none
// ============================================================================
// Module : req_fifo
// Brief  : Circular request storage with occupancy count and registered full.
// Rev    : 1.0  initial release
// ============================================================================
module req_fifo
    import mem_request_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  queue_entry_t           push_data,
    input  logic                   pop,
    output queue_entry_t           head_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    queue_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop on an empty queue is dropped; a push is only accepted when a slot exists.
    assign w_do_pop  = pop && (count_q != '0);
    assign w_do_push = push && (!full_q || w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - CNT_ONE;
        end
        full_d = (count_d == CNT_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Head is forced to zero when empty so stale or uninitialised storage never leaks out.
    assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign empty     = (count_q == '0);
    assign full      = full_q;
    assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_request_queue.sv
`default_nettype none
// ============================================================================
// Module : mem_request_queue
// Brief  : Owns simulation time, gates parser requests through a hold register
//          and buffers them for the DRAM command scheduler.
// Rev    : 1.0  initial release
// ============================================================================
module mem_request_queue
    import mem_request_queue_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_QUEUE_DEPTH,
    parameter int TIME_W = TIMESTAMP_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  parser_out_struct_t     in_req,
    output logic [TIME_W-1:0]      queue_time,
    output logic                   queue_full,
    output logic                   pending_request,
    output logic                   head_valid,
    output queue_entry_t           head_entry,
    output logic [TIME_W-1:0]      head_wait,
    input  logic                   head_pop,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

    hold_state_t                state_q, state_d;
    parsed_op_t                 hold_op_q, hold_op_d;
    logic [ADDRESS_WIDTH-1:0]   hold_addr_q, hold_addr_d;
    logic [TIMESTAMP_WIDTH-1:0] hold_time_q, hold_time_d;
    logic [TIME_W-1:0]          queue_time_q, queue_time_d;
    logic                       pending_q, pending_d;

    logic                       w_push;
    logic                       w_pop;
    logic                       w_space;
    logic                       w_time_ready;
    logic                       w_fifo_empty;
    logic                       w_fifo_full;
    logic [CNT_W-1:0]           w_count;
    logic [TIME_W-1:0]          w_time_next;
    logic [TIME_W-1:0]          w_hold_time;
    queue_entry_t               w_push_entry;
    queue_entry_t               w_head;

    assign w_pop        = head_pop && !w_fifo_empty;
    assign w_space      = !w_fifo_full || w_pop;
    assign w_hold_time  = TIME_W'(hold_time_q);
    assign w_time_ready = (queue_time_q >= w_hold_time);
    assign w_time_next  = queue_time_q + TIME_ONE;

    always_comb begin
        state_d     = state_q;
        hold_op_d   = hold_op_q;
        hold_addr_d = hold_addr_q;
        hold_time_d = hold_time_q;
        w_push      = 1'b0;
        case (state_q)
            H_EMPTY: begin
                if (in_req.op_ready_s) begin
                    hold_op_d   = in_req.opcode;
                    hold_addr_d = in_req.address;
                    hold_time_d = in_req.time_cpu;
                    state_d     = H_TIME;
                end
            end
            H_TIME: begin
                if (w_time_ready) begin
                    if (w_space) begin
                        w_push  = 1'b1;
                        state_d = H_EMPTY;
                    end else begin
                        state_d = H_SPACE;
                    end
                end
            end
            H_SPACE: begin
                if (w_space) begin
                    w_push  = 1'b1;
                    state_d = H_EMPTY;
                end
            end
            default: state_d = H_EMPTY;
        endcase
        pending_d = (state_d != H_EMPTY);
    end

    // With nothing queued and the held request far in the future, jump straight to it.
    always_comb begin
        queue_time_d = w_time_next;
        if ((w_count == '0) && (state_q == H_TIME) && (w_hold_time > w_time_next)) begin
            queue_time_d = w_hold_time;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= H_EMPTY;
            hold_op_q    <= OP_READ;
            hold_addr_q  <= '0;
            hold_time_q  <= '0;
            queue_time_q <= '0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_op_q    <= hold_op_d;
            hold_addr_q  <= hold_addr_d;
            hold_time_q  <= hold_time_d;
            queue_time_q <= queue_time_d;
            pending_q    <= pending_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
        end else if ((state_q == H_EMPTY) && in_req.op_ready_s) begin
            assert (is_legal_op(in_req.opcode))
            else $error("mem_request_queue: illegal opcode %0d latched", in_req.opcode);
        end
    end

    always_comb begin
        w_push_entry          = '0;
        w_push_entry.opcode   = hold_op_q;
        w_push_entry.address  = hold_addr_q;
        w_push_entry.time_cpu = hold_time_q;
        w_push_entry.t_enq    = TIMESTAMP_WIDTH'(queue_time_q);
    end

    req_fifo #(
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .count     (w_count)
    );

    assign queue_time      = queue_time_q;
    assign queue_full      = w_fifo_full;
    assign pending_request = pending_q;
    assign head_valid      = !w_fifo_empty;
    assign head_entry      = w_head;
    assign head_wait       = queue_time_q - TIME_W'(w_head.t_enq);
    assign occupancy       = w_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_request_queue
// Brief  : Self-checking bench for mem_request_queue (vector table + scoreboard).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_request_queue;
    import mem_request_queue_pkg::*;

    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    parser_out_struct_t in_req;
    logic [31:0]        queue_time;
    logic               queue_full;
    logic               pending_request;
    logic               head_valid;
    queue_entry_t       head_entry;
    logic [31:0]        head_wait;
    logic               head_pop;
    logic [4:0]         occupancy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] time_cpu;
        parsed_op_t  op;
        logic [31:0] t_enq;
        bit          chk_t;
    } exp_t;

    typedef struct {
        int          idle;
        logic [31:0] time_cpu;
        parsed_op_t  op;
        logic [31:0] exp_t_enq;
    } vec_t;

    exp_t sb[$];

    mem_request_queue #(
        .DEPTH  (DEPTH),
        .TIME_W (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_req          (in_req),
        .queue_time      (queue_time),
        .queue_full      (queue_full),
        .pending_request (pending_request),
        .head_valid      (head_valid),
        .head_entry      (head_entry),
        .head_wait       (head_wait),
        .head_pop        (head_pop),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout/underflow required=event", name);
    endtask

    // Asserts reset between edges so the outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        in_req = '0;
        head_pop = 1'b0;
        sb.delete();
        #1;
        check("rst_time", queue_time, 0);
        check("rst_occ", occupancy, 0);
        check("rst_flags", {queue_full, pending_request, head_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] addr, input logic [31:0] tc, input parsed_op_t op,
                        input logic [31:0] te, input bit chk);
        int   n;
        exp_t e;
        n = 0;
        while (pending_request && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) note_fail("send_wait");
        in_req.op_ready_s = 1'b1;
        in_req.opcode     = op;
        in_req.address    = addr;
        in_req.time_cpu   = tc;
        e.addr = addr; e.time_cpu = tc; e.op = op; e.t_enq = te; e.chk_t = chk;
        sb.push_back(e);
        @(negedge clk);
        in_req.op_ready_s = 1'b0;
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        check({tag, "_valid"}, head_valid, 1);
        if (sb.size() == 0) begin
            note_fail({tag, "_scoreboard_empty"});
            return;
        end
        e = sb.pop_front();
        check({tag, "_addr"}, head_entry.address, e.addr);
        check({tag, "_op"}, head_entry.opcode, e.op);
        check({tag, "_tcpu"}, head_entry.time_cpu, e.time_cpu);
        if (e.chk_t) begin
            check({tag, "_tenq"}, head_entry.t_enq, e.t_enq);
            check({tag, "_wait"}, head_wait, queue_time - e.t_enq);
        end else begin
            check({tag, "_wait"}, head_wait, queue_time - head_entry.t_enq);
            check({tag, "_tenq_ge_tcpu"}, head_entry.t_enq >= e.time_cpu, 1);
        end
    endtask

    task automatic pop_one(input string tag);
        check_head(tag);
        head_pop = 1'b1;
        @(negedge clk);
        head_pop = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        int   n;
        int   bad;
        int   issued;
        logic [31:0] last_t;
        exp_t e;

        vecs[0] = '{idle: 6, time_cpu: 32'd500,        op: OP_READ,   exp_t_enq: 32'd500};
        vecs[1] = '{idle: 2, time_cpu: 32'd0,          op: OP_WRITE,  exp_t_enq: 32'd3};
        vecs[2] = '{idle: 4, time_cpu: 32'd6,          op: OP_IFETCH, exp_t_enq: 32'd6};
        vecs[3] = '{idle: 4, time_cpu: 32'd7,          op: OP_READ,   exp_t_enq: 32'd7};
        vecs[4] = '{idle: 3, time_cpu: 32'd4,          op: OP_WRITE,  exp_t_enq: 32'd4};
        vecs[5] = '{idle: 0, time_cpu: 32'hFFFF_FFF0,  op: OP_IFETCH, exp_t_enq: 32'hFFFF_FFF0};

        in_req   = '0;
        head_pop = 1'b0;
        repeat (2) @(negedge clk);

        // Single requests into an empty queue: time gate and time skip boundaries.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            repeat (vecs[i].idle) @(negedge clk);
            send(32'hA000 + i, vecs[i].time_cpu, vecs[i].op, vecs[i].exp_t_enq, 1'b1);
            check($sformatf("vec%0d_pending", i), pending_request, 1);
            n = 0;
            while (!head_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) note_fail($sformatf("vec%0d_head_wait", i));
            check($sformatf("vec%0d_qtime", i), queue_time, vecs[i].exp_t_enq + 1);
            check($sformatf("vec%0d_occ", i), occupancy, 1);
            check_head($sformatf("vec%0d", i));
            check($sformatf("vec%0d_wait1", i), head_wait, 1);
        end

        // Reset in the middle of traffic, with a request still in the hold register.
        do_reset();
        for (int i = 0; i < 3; i++) send(32'hB000 + i, 32'd0, OP_READ, 0, 1'b0);
        send(32'hB0FF, 32'd1000, OP_WRITE, 0, 1'b0);
        check("mid_pending", pending_request, 1);
        check("mid_occ", occupancy, 3);
        do_reset();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (head_valid || pending_request || occupancy != 0) bad++;
        end
        check("post_reset_quiet", bad, 0);

        // Time gate with a non-empty queue: no skip, waits for queue_time to reach 10.
        do_reset();
        send(32'hC000, 32'd0, OP_READ, 32'd1, 1'b1);
        send(32'hC001, 32'd10, OP_WRITE, 32'd10, 1'b1);
        check("gate_qtime_latch", queue_time, 3);
        n = 0;
        while (pending_request && n < 30) begin
            if (queue_time > 10) bad++;
            @(negedge clk);
            n++;
        end
        if (n >= 30) note_fail("gate_timeout");
        check("gate_release_time", queue_time, 11);
        check("gate_occ", occupancy, 2);
        pop_one("gate0");
        pop_one("gate1");

        // Full queue: 17th request holds until a pop, then enters in the same cycle.
        do_reset();
        for (int i = 0; i < 17; i++) send(32'hD000 + i, 32'd0, OP_READ, 0, 1'b0);
        check("full_flag", queue_full, 1);
        check("full_pending", pending_request, 1);
        check("full_occ", occupancy, 16);
        @(negedge clk);
        check("full_hold_pending", pending_request, 1);
        check("full_hold_occ", occupancy, 16);
        pop_one("full_pop");
        check("full_after_occ", occupancy, 16);
        check("full_after_pending", pending_request, 0);
        check("full_after_flag", queue_full, 1);
        pop_one("drain0");
        check("drain_full_clear", queue_full, 0);
        for (int i = 1; i < 16; i++) pop_one($sformatf("drain%0d", i));
        check("drain_occ", occupancy, 0);
        check("drain_valid", head_valid, 0);

        // Pop on an empty queue is ignored.
        head_pop = 1'b1;
        repeat (3) @(negedge clk);
        check("empty_pop_occ", occupancy, 0);
        check("empty_pop_valid", head_valid, 0);
        check("empty_pop_noX", $isunknown({queue_time, queue_full, pending_request,
                                            head_entry, head_wait, occupancy}), 0);
        head_pop = 1'b0;

        // Random traffic across several pointer wraps.
        do_reset();
        issued = 0;
        last_t = 0;
        n = 0;
        while ((issued < 40 || sb.size() > 0) && n < 3000) begin
            in_req.op_ready_s = 1'b0;
            head_pop = 1'b0;
            if (issued < 40 && !pending_request && $urandom_range(0, 3) != 0) begin
                in_req.op_ready_s = 1'b1;
                in_req.opcode     = parsed_op_t'(issued % 3);
                in_req.address    = 32'hE000 + issued * 4;
                in_req.time_cpu   = queue_time + $urandom_range(0, 4);
                e.addr = in_req.address; e.time_cpu = in_req.time_cpu;
                e.op = in_req.opcode; e.t_enq = 0; e.chk_t = 1'b0;
                sb.push_back(e);
                issued++;
            end
            if (head_valid && $urandom_range(0, 9) < 4) begin
                check_head("wrap");
                check("wrap_tenq_order", head_entry.t_enq >= last_t, 1);
                last_t = head_entry.t_enq;
                head_pop = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        in_req.op_ready_s = 1'b0;
        head_pop = 1'b0;
        if (n >= 3000) note_fail("wrap_timeout");
        check("wrap_end_occ", occupancy, 0);
        check("gate_no_overrun", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
